ram_arbiter_rr: RTL and testbench

Parametrised N-port round-robin interconnect between NUM_PORTS burst requesters (core fetch, load/store, DMA) and the single RAM controller port. Write and read paths have independent arbiters, so one port's write burst and another port's read burst run concurrently. A grant is held from address handshake to the last data beat. Priority rotates after every completed burst.

---
 rtl/ram_arbiter_rr.sv | 194 +++++++++++++++++++
 tb/tb_ram_arbiter_rr.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter_rr.sv
// Round-robin interconnect from NUM_PORTS burst requesters onto one RAM controller port.
// Write and read paths arbitrate independently; a grant spans address handshake to last beat.
module ram_arbiter_rr #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned AWIDTH    = 32,
    parameter int unsigned DWIDTH    = 32,
    parameter int unsigned LWIDTH    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    // requester side, write
    input  logic [NUM_PORTS*AWIDTH-1:0] s_awaddr,
    input  logic [NUM_PORTS*LWIDTH-1:0] s_awlen,
    input  logic [NUM_PORTS-1:0]        s_awvalid,
    output logic [NUM_PORTS-1:0]        s_awready,
    input  logic [NUM_PORTS*DWIDTH-1:0] s_wdata,
    output logic [NUM_PORTS-1:0]        s_wvalid,
    output logic [NUM_PORTS-1:0]        s_wlast,
    input  logic [NUM_PORTS-1:0]        s_wready,
    // requester side, read
    input  logic [NUM_PORTS*AWIDTH-1:0] s_araddr,
    input  logic [NUM_PORTS*LWIDTH-1:0] s_arlen,
    input  logic [NUM_PORTS-1:0]        s_arvalid,
    output logic [NUM_PORTS-1:0]        s_arready,
    output logic [NUM_PORTS*DWIDTH-1:0] s_rdata,
    output logic [NUM_PORTS-1:0]        s_rvalid,
    output logic [NUM_PORTS-1:0]        s_rlast,
    input  logic [NUM_PORTS-1:0]        s_rready,
    // RAM controller side
    output logic [AWIDTH-1:0]           m_awaddr,
    output logic [LWIDTH-1:0]           m_awlen,
    output logic                        m_awvalid,
    input  logic                        m_awready,
    output logic [DWIDTH-1:0]           m_wdata,
    input  logic                        m_wvalid,
    input  logic                        m_wlast,
    output logic                        m_wready,
    output logic [AWIDTH-1:0]           m_araddr,
    output logic [LWIDTH-1:0]           m_arlen,
    output logic                        m_arvalid,
    input  logic                        m_arready,
    input  logic [DWIDTH-1:0]           m_rdata,
    input  logic                        m_rvalid,
    input  logic                        m_rlast,
    output logic                        m_rready,
    output logic [NUM_PORTS-1:0]        wgrant,
    output logic [NUM_PORTS-1:0]        rgrant
);
    localparam int unsigned PW = $clog2(NUM_PORTS);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StAddr = 2'd1;
    localparam logic [1:0] StData = 2'd2;

    localparam logic [LWIDTH:0] CntOne = (LWIDTH+1)'(1);

    // First requester at or after ptr, wrapping; lowest offset wins.
    function automatic logic [PW-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                              input logic [PW-1:0] ptr);
        logic [PW-1:0] pick;
        int unsigned   idx;
        pick = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx = (32'(ptr) + 32'(k)) % NUM_PORTS;
            if (req[idx]) pick = PW'(idx);
        end
        return pick;
    endfunction

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] g);
        return (g == PW'(NUM_PORTS - 1)) ? '0 : g + 1'b1;
    endfunction

    logic [1:0]      wst_q, rst_q;
    logic [PW-1:0]   wg_q, rg_q, wptr_q, rptr_q;
    logic [LWIDTH:0] wcnt_q, rcnt_q;
    logic            werr_q, rerr_q;
    logic            w_beat, r_beat;

    assign w_beat = m_wvalid && m_wready;
    assign r_beat = m_rvalid && m_rready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wst_q  <= StIdle;
            wg_q   <= '0;
            wptr_q <= '0;
            wcnt_q <= '0;
            werr_q <= 1'b0;
        end else begin
            case (wst_q)
                StIdle: if (|s_awvalid) begin
                    wg_q  <= rr_pick(s_awvalid, wptr_q);
                    wst_q <= StAddr;
                end
                StAddr: if (m_awvalid && m_awready) begin
                    wcnt_q <= {1'b0, m_awlen} + 1'b1;
                    wst_q  <= StData;
                end
                StData: if (w_beat) begin
                    wcnt_q <= wcnt_q - 1'b1;
                    if (m_wlast) begin
                        wst_q  <= StIdle;
                        wptr_q <= next_ptr(wg_q);
                    end
                end
                default: wst_q <= StIdle;
            endcase
            // Length/last disagreement is recorded but never alters the grant.
            if (w_beat && ((m_wlast != (wcnt_q == CntOne)) || (wcnt_q == '0))) werr_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rst_q  <= StIdle;
            rg_q   <= '0;
            rptr_q <= '0;
            rcnt_q <= '0;
            rerr_q <= 1'b0;
        end else begin
            case (rst_q)
                StIdle: if (|s_arvalid) begin
                    rg_q  <= rr_pick(s_arvalid, rptr_q);
                    rst_q <= StAddr;
                end
                StAddr: if (m_arvalid && m_arready) begin
                    rcnt_q <= {1'b0, m_arlen} + 1'b1;
                    rst_q  <= StData;
                end
                StData: if (r_beat) begin
                    rcnt_q <= rcnt_q - 1'b1;
                    if (m_rlast) begin
                        rst_q  <= StIdle;
                        rptr_q <= next_ptr(rg_q);
                    end
                end
                default: rst_q <= StIdle;
            endcase
            if (r_beat && ((m_rlast != (rcnt_q == CntOne)) || (rcnt_q == '0))) rerr_q <= 1'b1;
        end
    end

    always_comb begin
        m_awaddr  = '0;
        m_awlen   = '0;
        m_awvalid = 1'b0;
        s_awready = '0;
        m_wdata   = '0;
        m_wready  = 1'b0;
        s_wvalid  = '0;
        s_wlast   = '0;
        wgrant    = '0;
        if (wst_q != StIdle) wgrant[wg_q] = 1'b1;
        if (wst_q == StAddr) begin
            m_awaddr        = s_awaddr[int'(wg_q)*AWIDTH +: AWIDTH];
            m_awlen         = s_awlen[int'(wg_q)*LWIDTH +: LWIDTH];
            m_awvalid       = s_awvalid[wg_q];
            s_awready[wg_q] = m_awready;
        end
        if (wst_q == StData) begin
            m_wdata        = s_wdata[int'(wg_q)*DWIDTH +: DWIDTH];
            m_wready       = s_wready[wg_q];
            s_wvalid[wg_q] = m_wvalid;
            s_wlast[wg_q]  = m_wlast;
        end
    end

    always_comb begin
        m_araddr  = '0;
        m_arlen   = '0;
        m_arvalid = 1'b0;
        s_arready = '0;
        s_rdata   = '0;
        s_rvalid  = '0;
        s_rlast   = '0;
        m_rready  = 1'b0;
        rgrant    = '0;
        if (rst_q != StIdle) rgrant[rg_q] = 1'b1;
        if (rst_q == StAddr) begin
            m_araddr        = s_araddr[int'(rg_q)*AWIDTH +: AWIDTH];
            m_arlen         = s_arlen[int'(rg_q)*LWIDTH +: LWIDTH];
            m_arvalid       = s_arvalid[rg_q];
            s_arready[rg_q] = m_arready;
        end
        if (rst_q == StData) begin
            s_rdata[int'(rg_q)*DWIDTH +: DWIDTH] = m_rdata;
            s_rvalid[rg_q] = m_rvalid;
            s_rlast[rg_q]  = m_rlast;
            m_rready       = s_rready[rg_q];
        end
    end

endmodule

// File: tb/tb_ram_arbiter_rr.sv
// Randomized bench for ram_arbiter_rr: a per-port owner/ptr reference model predicts every
// output each cycle while requesters and the RAM side are driven with biased random traffic.
module tb_ram_arbiter_rr;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 8;
    localparam int NCYC = 3000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N*AW-1:0] s_awaddr, s_araddr;
    logic [N*LW-1:0] s_awlen, s_arlen;
    logic [N*DW-1:0] s_wdata, s_rdata;
    logic [N-1:0]    s_awvalid, s_awready, s_wvalid, s_wlast, s_wready;
    logic [N-1:0]    s_arvalid, s_arready, s_rvalid, s_rlast, s_rready, wgrant, rgrant;
    logic [AW-1:0]   m_awaddr, m_araddr;
    logic [LW-1:0]   m_awlen, m_arlen;
    logic [DW-1:0]   m_wdata, m_rdata;
    logic            m_awvalid, m_awready, m_wvalid, m_wlast, m_wready;
    logic            m_arvalid, m_arready, m_rvalid, m_rlast, m_rready;

    ram_arbiter_rr #(.NUM_PORTS(N), .AWIDTH(AW), .DWIDTH(DW), .LWIDTH(LW)) dut (
        .clk(clk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wlast(s_wlast), .s_wready(s_wready),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rlast(s_rlast), .s_rready(s_rready),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_wready(m_wready),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rready(m_rready),
        .wgrant(wgrant), .rgrant(rgrant)
    );

    // Requester-side stimulus kept per port, packed onto the flat buses each cycle.
    logic [AW-1:0] aw_addr[N], ar_addr[N];
    logic [LW-1:0] aw_len[N], ar_len[N];
    logic [DW-1:0] wdata[N];
    logic [N-1:0]  aw_pend, ar_pend, wrdy, rrdy;

    // Reference model: owner = -1 when the path is free.
    int w_own, r_own, w_ptr, r_ptr;
    bit w_addr, r_addr;

    logic [N-1:0]    e_awready, e_wvalid, e_wlast, e_arready, e_rvalid, e_rlast, e_wgrant, e_rgrant;
    logic [N*DW-1:0] e_rdata;
    logic [AW-1:0]   e_awaddr, e_araddr;
    logic [LW-1:0]   e_awlen, e_arlen;
    logic [DW-1:0]   e_wdata;
    logic            e_awvalid, e_wready, e_arvalid, e_rready;

    int n_total = 0;
    int n_pass  = 0;
    int cyc;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        else n_pass++;
    endtask

    function automatic int pick(input logic [N-1:0] req, input int ptr);
        for (int i = 0; i < N; i++) if (req[(ptr + i) % N]) return (ptr + i) % N;
        return -1;
    endfunction

    task automatic predict();
        e_awready = '0; e_wvalid = '0; e_wlast = '0; e_wgrant = '0;
        e_arready = '0; e_rvalid = '0; e_rlast = '0; e_rgrant = '0; e_rdata = '0;
        e_awaddr = '0; e_awlen = '0; e_awvalid = 1'b0; e_wdata = '0; e_wready = 1'b0;
        e_araddr = '0; e_arlen = '0; e_arvalid = 1'b0; e_rready = 1'b0;
        if (w_own >= 0) begin
            e_wgrant[w_own] = 1'b1;
            if (w_addr) begin
                e_awaddr = aw_addr[w_own]; e_awlen = aw_len[w_own];
                e_awvalid = aw_pend[w_own]; e_awready[w_own] = m_awready;
            end else begin
                e_wdata = wdata[w_own]; e_wready = wrdy[w_own];
                e_wvalid[w_own] = m_wvalid; e_wlast[w_own] = m_wlast;
            end
        end
        if (r_own >= 0) begin
            e_rgrant[r_own] = 1'b1;
            if (r_addr) begin
                e_araddr = ar_addr[r_own]; e_arlen = ar_len[r_own];
                e_arvalid = ar_pend[r_own]; e_arready[r_own] = m_arready;
            end else begin
                e_rdata[r_own*DW +: DW] = m_rdata; e_rready = rrdy[r_own];
                e_rvalid[r_own] = m_rvalid; e_rlast[r_own] = m_rlast;
            end
        end
    endtask

    task automatic compare_all();
        check("wgrant", wgrant, e_wgrant);       check("rgrant", rgrant, e_rgrant);
        check("m_awaddr", m_awaddr, e_awaddr);   check("m_awlen", m_awlen, e_awlen);
        check("m_awvalid", m_awvalid, e_awvalid); check("s_awready", s_awready, e_awready);
        check("m_wdata", m_wdata, e_wdata);      check("m_wready", m_wready, e_wready);
        check("s_wvalid", s_wvalid, e_wvalid);   check("s_wlast", s_wlast, e_wlast);
        check("m_araddr", m_araddr, e_araddr);   check("m_arlen", m_arlen, e_arlen);
        check("m_arvalid", m_arvalid, e_arvalid); check("s_arready", s_arready, e_arready);
        check("s_rdata", s_rdata, e_rdata);      check("m_rready", m_rready, e_rready);
        check("s_rvalid", s_rvalid, e_rvalid);   check("s_rlast", s_rlast, e_rlast);
    endtask

    // Advance the model across one clock edge using the inputs currently applied.
    task automatic model_step();
        int p;
        aw_pend = aw_pend & ~(e_awready & aw_pend);
        ar_pend = ar_pend & ~(e_arready & ar_pend);
        if (rst) begin
            w_own = -1; w_addr = 0; w_ptr = 0;
            r_own = -1; r_addr = 0; r_ptr = 0;
            return;
        end
        if (w_own < 0) begin
            p = pick(s_awvalid, w_ptr);
            if (p >= 0) begin w_own = p; w_addr = 1; end
        end else if (w_addr) begin
            if (s_awvalid[w_own] && m_awready) w_addr = 0;
        end else if (m_wvalid && wrdy[w_own] && m_wlast) begin
            w_ptr = (w_own + 1) % N; w_own = -1;
        end
        if (r_own < 0) begin
            p = pick(s_arvalid, r_ptr);
            if (p >= 0) begin r_own = p; r_addr = 1; end
        end else if (r_addr) begin
            if (s_arvalid[r_own] && m_arready) r_addr = 0;
        end else if (m_rvalid && rrdy[r_own] && m_rlast) begin
            r_ptr = (r_own + 1) % N; r_own = -1;
        end
    endtask

    initial begin
        logic [N-1:0] wmask, rmask;
        int rst_pct, drop_pct;
        w_own = -1; r_own = -1; w_ptr = 0; r_ptr = 0; w_addr = 0; r_addr = 0;
        aw_pend = '0; ar_pend = '0; wrdy = '0; rrdy = '0;
        for (int p = 0; p < N; p++) begin
            aw_addr[p] = '0; ar_addr[p] = '0; aw_len[p] = '0; ar_len[p] = '0; wdata[p] = '0;
        end
        for (cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            // Traffic phases: single writer, write contention, read rotation, W/R overlap, chaos.
            rst_pct = 0; drop_pct = 0;
            if (cyc < 200)       begin wmask = 4'b0100; rmask = 4'b0000; end
            else if (cyc < 600)  begin wmask = 4'b1111; rmask = 4'b0000; end
            else if (cyc < 800)  begin wmask = 4'b0000; rmask = 4'b1010; end
            else if (cyc < 1000) begin wmask = 4'b0000; rmask = 4'b1011; end
            else if (cyc < 1400) begin wmask = 4'b0001; rmask = 4'b0010; end
            else begin wmask = 4'b1111; rmask = 4'b1111; rst_pct = 1; drop_pct = 3; end
            rst = (cyc < 2) || ($urandom_range(99) < rst_pct);
            for (int p = 0; p < N; p++) begin
                if (!aw_pend[p] && wmask[p] && $urandom_range(99) < 40) begin
                    aw_pend[p] = 1'b1; aw_addr[p] = $urandom; aw_len[p] = LW'($urandom_range(7));
                end else if (aw_pend[p] && $urandom_range(99) < drop_pct) aw_pend[p] = 1'b0;
                if (!ar_pend[p] && rmask[p] && $urandom_range(99) < 40) begin
                    ar_pend[p] = 1'b1; ar_addr[p] = $urandom; ar_len[p] = LW'($urandom_range(7));
                end else if (ar_pend[p] && $urandom_range(99) < drop_pct) ar_pend[p] = 1'b0;
                wdata[p] = $urandom;
                wrdy[p]  = $urandom_range(99) < 80;
                rrdy[p]  = $urandom_range(99) < 80;
                s_awaddr[p*AW +: AW] = aw_addr[p]; s_awlen[p*LW +: LW] = aw_len[p];
                s_araddr[p*AW +: AW] = ar_addr[p]; s_arlen[p*LW +: LW] = ar_len[p];
                s_wdata[p*DW +: DW]  = wdata[p];
            end
            s_awvalid = aw_pend; s_arvalid = ar_pend; s_wready = wrdy; s_rready = rrdy;
            m_awready = $urandom_range(99) < 60;
            m_arready = $urandom_range(99) < 60;
            m_wvalid  = $urandom_range(99) < 70;
            m_wlast   = $urandom_range(99) < 25;
            m_rvalid  = $urandom_range(99) < 70;
            m_rlast   = $urandom_range(99) < 25;
            m_rdata   = $urandom;
            #1;
            predict();
            // Before the first edge the DUT state is still unknown.
            if (cyc > 0) compare_all();
            model_step();
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
